// File: rtl/audio_seq_pkg.sv
// Shared constants for the audio sample sequencer: register map, STATUS/CTRL bit positions, state encoding.
package audio_seq_pkg;

  localparam logic [15:0] ADDR_DATA   = 16'h0000;
  localparam logic [15:0] ADDR_DIV    = 16'h0004;
  localparam logic [15:0] ADDR_CTRL   = 16'h0008;
  localparam logic [15:0] ADDR_THRESH = 16'h000C;

  localparam int STAT_EMPTY_BIT = 8;
  localparam int STAT_FULL_BIT  = 9;
  localparam int STAT_OVF_BIT   = 10;
  localparam int STAT_UND_BIT   = 11;
  localparam int STAT_STATE_LSB = 12;

  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_FLUSH_BIT  = 1;
  localparam int CTRL_CLR_BIT    = 2;

  localparam logic [7:0] PCM_MIDSCALE = 8'h80;
  localparam logic [7:0] THRESH_RESET = 8'd4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_RUN      = 2'b01,
    ST_UNDERRUN = 2'b10
  } seq_state_e;

endpackage

// File: rtl/audio_seq_fifo.sv
// Sample FIFO with registered read port; the read register doubles as the held PCM output value.
module audio_seq_fifo #(
  parameter int         DEPTH      = 16,
  parameter logic [7:0] RESET_DATA = 8'h80,
  localparam int        AW         = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  logic [7:0]  wr_data,
  output logic [7:0]  rd_data,
  output logic [AW:0] level,
  output logic        empty,
  output logic        full
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [7:0]    rd_data_q;
  logic          do_push, do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == (AW+1)'(DEPTH));
  assign level   = level_q;
  assign rd_data = rd_data_q;

  // A pop frees the slot a same-cycle push needs, so a full FIFO still accepts it.
  always_comb begin
    do_pop  = pop && !empty && !flush;
    do_push = push && (!full || do_pop) && !flush;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      level_d  = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rd_data_q <= RESET_DATA;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (do_pop) rd_data_q <= mem[rd_ptr_q];
    end
  end

endmodule

// File: rtl/audio_sample_sequencer.sv
// Register-programmed sample sequencer feeding a PWM datapath at a divided sample rate.
// Define AUDIO_SEQ_IRQ_EN to add the level/underrun interrupt and the THRESH register.
module audio_sample_sequencer
  import audio_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_RESET  = 2499
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  ctrl_wr,
  input  logic        ctrl_rd,
  input  logic [15:0] ctrl_addr,
  input  logic [31:0] ctrl_wdat,
  output logic [31:0] ctrl_rdat,
  output logic        ctrl_done,
  output logic [7:0]  pcm_data,
`ifdef AUDIO_SEQ_IRQ_EN
  output logic        irq,
`endif
  output logic        pcm_valid
);

  localparam int AW = $clog2(FIFO_DEPTH);

  seq_state_e  state_q, state_d;
  logic [15:0] div_q, div_d, cnt_q, cnt_d;
  logic        enable_q, enable_d, ovf_q, ovf_d, und_q, und_d;
  logic        done_q, done_d, valid_q, valid_d;
  logic [31:0] rdat_q, rdat_d;
  logic        access, wr_en, rd_en, ctrl_hit, push, pop, flush, clr_flags, tick;
  logic [AW:0] level;
  logic [7:0]  level8;
  logic        empty, full;
  logic [31:0] status, rd_val;
  logic        unused_wdat;
`ifdef AUDIO_SEQ_IRQ_EN
  logic [7:0]  thresh_q, thresh_d;
  logic        irq_q, irq_d;
  assign irq = irq_q;
`endif

  assign unused_wdat = ^ctrl_wdat[31:16];
  assign level8      = 8'(level);
  assign ctrl_rdat   = rdat_q;
  assign ctrl_done   = done_q;
  assign pcm_valid   = valid_q;

  audio_seq_fifo #(.DEPTH(FIFO_DEPTH), .RESET_DATA(PCM_MIDSCALE)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wr_data (ctrl_wdat[7:0]),
    .rd_data (pcm_data),
    .level   (level),
    .empty   (empty),
    .full    (full)
  );

  // An access is only taken while done is low, which enforces the idle cycle after each ack.
  always_comb begin
    access    = ((|ctrl_wr) || ctrl_rd) && !done_q;
    wr_en     = access && (|ctrl_wr);
    rd_en     = access && ctrl_rd && !(|ctrl_wr);
    push      = wr_en && (ctrl_addr == ADDR_DATA);
    ctrl_hit  = wr_en && (ctrl_addr == ADDR_CTRL) && ctrl_wr[0];
    flush     = ctrl_hit && ctrl_wdat[CTRL_FLUSH_BIT];
    clr_flags = ctrl_hit && ctrl_wdat[CTRL_CLR_BIT];
    tick      = enable_q && (state_q != ST_IDLE) && (cnt_q == '0);
    pop       = tick && !empty && !flush;
  end

  always_comb begin
    status                          = '0;
    status[7:0]                     = level8;
    status[STAT_EMPTY_BIT]          = empty;
    status[STAT_FULL_BIT]           = full;
    status[STAT_OVF_BIT]            = ovf_q;
    status[STAT_UND_BIT]            = und_q;
    status[STAT_STATE_LSB +: 2]     = state_q;
    rd_val = '0;
    case (ctrl_addr)
      ADDR_DATA: rd_val = status;
      ADDR_DIV:  rd_val = {16'h0000, div_q};
      ADDR_CTRL: rd_val[CTRL_ENABLE_BIT] = enable_q;
`ifdef AUDIO_SEQ_IRQ_EN
      ADDR_THRESH: rd_val = {24'h0, thresh_q};
`endif
      default: rd_val = '0;
    endcase
  end

  always_comb begin
    done_d   = access;
    rdat_d   = rd_en ? rd_val : '0;
    valid_d  = pop;
    div_d    = div_q;
    enable_d = enable_q;
    if (wr_en && (ctrl_addr == ADDR_DIV)) begin
      if (ctrl_wr[0]) div_d[7:0]  = ctrl_wdat[7:0];
      if (ctrl_wr[1]) div_d[15:8] = ctrl_wdat[15:8];
    end
    if (ctrl_hit) enable_d = ctrl_wdat[CTRL_ENABLE_BIT];

    // Counter idles at DIV so the first RUN tick comes a full period after enable.
    if (!enable_q || state_q == ST_IDLE || cnt_q == '0) cnt_d = div_q;
    else cnt_d = cnt_q - 16'd1;

    ovf_d = clr_flags ? 1'b0 : ovf_q;
    und_d = clr_flags ? 1'b0 : und_q;
    if (push && full && !pop) ovf_d = 1'b1;

    state_d = state_q;
    if (!enable_q) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_RUN;
        ST_RUN: begin
          if (tick && empty) begin
            state_d = ST_UNDERRUN;
            und_d   = 1'b1;
          end
        end
        ST_UNDERRUN: if (pop) state_d = ST_RUN;
        default: state_d = ST_IDLE;
      endcase
    end
  end

`ifdef AUDIO_SEQ_IRQ_EN
  always_comb begin
    thresh_d = thresh_q;
    if (wr_en && (ctrl_addr == ADDR_THRESH) && ctrl_wr[0]) thresh_d = ctrl_wdat[7:0];
    irq_d = enable_q && ((level8 <= thresh_q) || und_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      thresh_q <= THRESH_RESET;
      irq_q    <= 1'b0;
    end else begin
      thresh_q <= thresh_d;
      irq_q    <= irq_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      div_q    <= 16'(DIV_RESET);
      cnt_q    <= 16'(DIV_RESET);
      enable_q <= 1'b0;
      ovf_q    <= 1'b0;
      und_q    <= 1'b0;
      done_q   <= 1'b0;
      rdat_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      enable_q <= enable_d;
      ovf_q    <= ovf_d;
      und_q    <= und_d;
      done_q   <= done_d;
      rdat_q   <= rdat_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: doc/audio_sample_sequencer.md
AUDIO_SAMPLE_SEQUENCER -- requirements
Module: audio_sample_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, sample FIFO depth in entries (power of two, 4..64).
REQ-002 Parameter DIV_RESET, default 2499, sample-period divider value loaded at reset (8 kHz at 20 MHz).
REQ-003 clk  input  1  sole clock; all logic on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 ctrl_wr  input  4  byte write strobes; any bit set means a write access.
REQ-006 ctrl_rd  input  1  read access request.
REQ-007 ctrl_addr  input  16  register address.
REQ-008 ctrl_wdat  input  32  write data.
REQ-009 ctrl_rdat  output  32  read data, valid when ctrl_done is high.
REQ-010 ctrl_done  output  1  one-cycle access acknowledge.
REQ-011 pcm_data  output  8  unsigned sample to the PWM datapath.
REQ-012 pcm_valid  output  1  one-cycle strobe; pcm_data is valid in the same cycle.

Function
REQ-013 Bus: an access (any ctrl_wr bit set, or ctrl_rd) while ctrl_done is low SHALL assert ctrl_done for exactly one cycle on the next edge; ctrl_done then stays low for at least one cycle.
REQ-014 Register map: 0x0 write pushes wdat[7:0] into the FIFO; 0x0 read returns STATUS; 0x4 is DIV[15:0] read/write; 0x8 is CTRL read/write (bit0 ENABLE, bit1 FLUSH is self-clearing, bit2 CLR_FLAGS is self-clearing).
REQ-015 STATUS SHALL be: [7:0] level, [8] empty, [9] full, [10] overflow sticky, [11] underrun sticky, [13:12] state encoding; other bits read 0.
REQ-016 Unmapped reads SHALL return 0; unmapped writes SHALL be acknowledged and ignored.
REQ-017 A push when the FIFO is full SHALL be dropped and SHALL set overflow; the FIFO contents SHALL remain unchanged.
REQ-018 Divider counter: counts down from DIV to 0; tick on 0 and reload DIV; sample period DIV+1 cycles; DIV=0 ticks every cycle; a DIV write takes effect at the next reload.
REQ-019 State machine: IDLE (00), RUN (01), UNDERRUN (10).
- IDLE: divider held at DIV; no pops.
- IDLE -> RUN when ENABLE=1.
- Any state -> IDLE when ENABLE=0.
REQ-020 RUN tick with the FIFO non-empty SHALL pop one sample, present it on pcm_data and pulse pcm_valid on the following cycle (latency 1).
REQ-021 RUN tick with the FIFO empty SHALL hold pcm_data, produce no pcm_valid, set underrun and move to UNDERRUN.
REQ-022 A UNDERRUN tick with the FIFO non-empty SHALL pop, strobe and return to RUN; the underrun flag stays set until cleared.
REQ-023 A push and a pop in the same cycle SHALL leave the level unchanged and be legal when the FIFO is full or empty; if the FIFO is empty, the popped value is not the pushed value (no bypass).
REQ-024 FLUSH SHALL empty the FIFO in one cycle; a pop coinciding with FLUSH SHALL be suppressed.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH; level is width log2(FIFO_DEPTH)+1.

Reset
REQ-026 Reset SHALL set: ctrl_done=0, ctrl_rdat=0, pcm_data=0x80 (midscale), pcm_valid=0, FIFO empty, flags 0, CTRL=0, DIV=DIV_RESET, state IDLE.
REQ-027 Reset asserted mid-operation SHALL abort an in-flight access with no ctrl_done, and any pending strobe SHALL be lost.

Configuration
REQ-028 With AUDIO_SEQ_IRQ_EN defined:
- Output irq (1 bit) and register 0xC THRESH[7:0] (reset 4) are added.
- irq = ENABLE && (level <= THRESH || underrun), registered, reset 0.
REQ-029 Without AUDIO_SEQ_IRQ_EN: no irq port; 0xC is unmapped.

Structure
REQ-030 Shared package audio_seq_pkg SHALL hold the register address constants, the STATUS/CTRL bit indices and the state encoding.
REQ-031 The FIFO SHALL be a sub-module audio_seq_fifo (push/pop/flush, data, level, empty, full).

Verification
REQ-032 DIV=3, ENABLE, push 0x10,0x20 -> pcm_valid every 4 cycles with 0x10 then 0x20; next tick gives underrun=1, STATE=10, pcm_data stays 0x20.
REQ-033 Push 17 samples with FIFO_DEPTH=16 while IDLE -> level=16, full=1, overflow=1; drained order is the first 16 values.
REQ-034 Simultaneous push and tick-pop at full and at level 1 -> level unchanged, no bypass, ordering preserved.
REQ-035 FLUSH on the same cycle as a tick -> no pcm_valid, level=0; CLR_FLAGS clears overflow and underrun.
REQ-036 Assert reset mid-stream -> all outputs at reset values, including pcm_data=0x80; accesses are acknowledged normally after release.
REQ-037 With AUDIO_SEQ_IRQ_EN, THRESH=2 -> irq rises when level drops to 2 and falls after pushes raise the level to 3.
